// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 UART receiver with a one-byte holding register and ready/overrun/framing status
// Ports: clk, reset (sync, active-low), uart_rx (async serial in, idle 1), rd_ack (CPU read pulse),
//        rx_data (last good byte), rx_ready (unread byte held), overrun / frame_err (sticky), rx_busy (frame in progress)
module uart_receiver #(
    parameter int BAUD_DIV = 326
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic       rd_ack,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       overrun,
    output logic       frame_err,
    output logic       rx_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    localparam logic [15:0] DIV_MAX = 16'(BAUD_DIV - 1);
    state_t      state_q, state_d;
    logic        sync_q, rx_s_q, rx_prev_q;
    logic [15:0] div_q, div_d;
    logic [3:0]  tcnt_q, tcnt_d;
    logic [2:0]  bidx_q, bidx_d;
    logic [7:0]  shift_q, shift_d, data_q, data_d;
    logic        ready_q, ready_d, ovr_q, ovr_d, ferr_q, ferr_d, busy_q, busy_d;
    logic        tick, commit, bad_stop, take;

    assign tick = div_q == DIV_MAX;

    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        bidx_d   = bidx_q;
        shift_d  = shift_q;
        div_d    = tick ? 16'd0 : div_q + 16'd1;
        commit   = 1'b0;
        bad_stop = 1'b0;
        case (state_q)
            IDLE: if (!rx_s_q && rx_prev_q) begin
                // restart the divider so every tick is phase-aligned to the start edge
                state_d = START;
                tcnt_d  = 4'd0;
                div_d   = 16'd0;
            end
            START: if (tick) begin
                tcnt_d = tcnt_q + 4'd1;
                if (tcnt_q == 4'd7) begin
                    state_d = rx_s_q ? IDLE : DATA;
                    tcnt_d  = 4'd0;
                    bidx_d  = 3'd0;
                end
            end
            DATA: if (tick) begin
                tcnt_d = tcnt_q + 4'd1;
                if (tcnt_q == 4'd15) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bidx_d  = bidx_q + 3'd1;
                    state_d = bidx_q == 3'd7 ? STOP : DATA;
                end
            end
            STOP: if (tick) begin
                tcnt_d = tcnt_q + 4'd1;
                if (tcnt_q == 4'd15) begin
                    commit   = rx_s_q;
                    bad_stop = !rx_s_q;
                    state_d  = rx_s_q ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: state_d = tick && rx_s_q ? IDLE : WAIT_IDLE;
            default: state_d = IDLE;
        endcase
    end

    // an ack landing in the commit cycle frees the register, so the new byte wins
    assign take    = commit && (!ready_q || rd_ack);
    assign data_d  = take ? shift_q : data_q;
    assign ready_d = commit || (ready_q && !rd_ack);
    assign ovr_d   = (commit && ready_q && !rd_ack) || (ovr_q && !rd_ack);
    assign ferr_d  = bad_stop || (ferr_q && !rd_ack);
    assign busy_d  = state_d != IDLE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            div_q     <= 16'd0;
            tcnt_q    <= 4'd0;
            bidx_q    <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            ready_q   <= 1'b0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= uart_rx;
            rx_s_q    <= sync_q;
            rx_prev_q <= rx_s_q;
            div_q     <= div_d;
            tcnt_q    <= tcnt_d;
            bidx_q    <= bidx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_ready  = ready_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver with directed cases and random frames
module tb_uart_receiver;
    localparam int B = 4;
    localparam int BIT = 16 * B;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rx = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_ready, overrun, frame_err, rx_busy;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         start_cyc = 0;
    int         commit_cyc = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_data = 8'h00;
    bit         m_ready = 0, m_ovr = 0, m_ferr = 0;
    logic       pr = 1'b0;
    logic [7:0] pd = 8'h00;

    uart_receiver #(.BAUD_DIV(B)) dut (
        .clk(clk), .reset(reset), .uart_rx(uart_rx), .rd_ack(rd_ack),
        .rx_data(rx_data), .rx_ready(rx_ready), .overrun(overrun),
        .frame_err(frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: run exceeded 80000 cycles");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (reset === 1'b1 && rx_ready === 1'b1 && (!pr || rx_data !== pd)) begin
            total++;
            commit_cyc = cyc;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got byte %02h, none expected", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    bad++;
                    $display("FAIL sb_byte: got %02h, want %02h", rx_data, e);
                end
            end
        end
        pr = rx_ready;
        pd = rx_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_data"}, 32'(rx_data), 32'(m_data));
        chk({tag, "_ready"}, 32'(rx_ready), 32'(m_ready));
        chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
        chk({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
        chk({tag, "_busy"}, 32'(rx_busy), 32'd0);
    endtask

    // model of the holding register: decides at issue time what the frame will do
    task automatic issue(input logic [7:0] b, input bit collide);
        if (!m_ready || collide) begin
            exp_q.push_back(b);
            m_data = b;
            m_ready = 1;
            m_ovr = 0;
            if (collide) m_ferr = 0;
        end else m_ovr = 1;
    endtask

    task automatic ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        m_ready = 0;
        m_ovr = 0;
        m_ferr = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // rst_bit: line-bit index (0 = start bit) during which reset is pulsed, -1 for none
    task automatic send_frame(input logic [7:0] b, input logic stopb, input int per, input int rst_bit);
        logic [9:0] f;
        f = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = f[i];
            if (i == 0) start_cyc = cyc;
            if (i == rst_bit) begin
                repeat (per / 2) @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                repeat (per - per / 2 - 2) @(negedge clk);
            end else repeat (per - 1) @(negedge clk);
        end
    endtask

    initial begin
        int d;
        repeat (5) @(negedge clk);
        chk_all("reset");
        reset = 1'b1;
        idle(10);

        issue(8'h55, 0);
        send_frame(8'h55, 1'b1, BIT, -1);
        idle(10);
        chk_all("basic");
        d = commit_cyc - start_cyc;
        total++;
        if (d < 609 || d > 613) begin
            bad++;
            $display("FAIL latency: got %0d clk, want 609..613", d);
        end
        ack();
        chk_all("basic_ack");

        @(negedge clk);
        uart_rx = 1'b0;
        idle(10);
        chk("glitch_busy_mid", 32'(rx_busy), 32'd1);
        idle(10);
        uart_rx = 1'b1;
        idle(100);
        chk_all("glitch");

        send_frame(8'hA3, 1'b0, BIT, -1);
        m_ferr = 1;
        idle(200);
        chk("ferr_set", 32'(frame_err), 32'd1);
        chk("ferr_ready", 32'(rx_ready), 32'd0);
        chk("ferr_data", 32'(rx_data), 32'(m_data));
        uart_rx = 1'b1;
        idle(40);
        issue(8'h3C, 0);
        send_frame(8'h3C, 1'b1, BIT, -1);
        idle(10);
        chk_all("after_ferr");
        ack();
        chk_all("after_ferr_ack");

        issue(8'h12, 0);
        send_frame(8'h12, 1'b1, BIT, -1);
        issue(8'h34, 0);
        send_frame(8'h34, 1'b1, BIT, -1);
        idle(10);
        chk_all("overrun");
        ack();
        chk_all("overrun_ack");

        issue(8'h12, 0);
        send_frame(8'h12, 1'b1, BIT, -1);
        idle(10);
        issue(8'h34, 1);
        fork
            send_frame(8'h34, 1'b1, BIT, -1);
            begin
                @(negedge clk);
                repeat (610) @(negedge clk);
                chk("coll_pending", 32'(rx_ready), 32'd1);
                rd_ack = 1'b1;
                @(negedge clk);
                rd_ack = 1'b0;
                chk("coll_ready", 32'(rx_ready), 32'd1);
                chk("coll_data", 32'(rx_data), 32'h34);
                chk("coll_ovr", 32'(overrun), 32'd0);
            end
        join
        idle(10);
        chk_all("collision");
        ack();

        send_frame(8'hF0, 1'b1, BIT, 5);
        m_data = 8'h00;
        m_ready = 0;
        m_ovr = 0;
        m_ferr = 0;
        idle(20);
        chk_all("rst_mid");
        issue(8'h81, 0);
        send_frame(8'h81, 1'b1, BIT, -1);
        idle(10);
        chk_all("after_rst");

        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            if ($urandom_range(0, 1) == 1) ack();
            b = 8'($urandom);
            issue(b, 0);
            send_frame(b, 1'b1, $urandom_range(BIT - 1, BIT + 1), -1);
            idle(2);
            chk_all("rand");
            idle($urandom_range(0, 30));
        end

        idle(50);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
